// File: rtl/kgp_pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, register address width
// and the control words driven by the hazard/flush controller.
package kgp_pipe_pkg;

  localparam int REG_AW      = 5;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pc_sel;
    logic flush;
    logic ifid_flush;
  } ctrl_t;

  // NOP word: nothing advances and nothing is bubbled (frozen pipeline)
  localparam ctrl_t CTRL_NOP    = '{pc_write: 1'b0, ifid_write: 1'b0, pc_sel: 1'b0, flush: 1'b0, ifid_flush: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, pc_sel: 1'b0, flush: 1'b0, ifid_flush: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, pc_sel: 1'b0, flush: 1'b1, ifid_flush: 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, pc_sel: 1'b0, flush: 1'b1, ifid_flush: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, pc_sel: 1'b1, flush: 1'b1, ifid_flush: 1'b1};
  localparam ctrl_t CTRL_SQUASH = '{pc_write: 1'b1, ifid_write: 1'b1, pc_sel: 1'b0, flush: 1'b1, ifid_flush: 1'b1};

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and the stall/flush/redirect
// controls plus debug/perf outputs. The controller takes the slave side.
interface hazard_flush_ctrl_if #(
  parameter int REG_AW = kgp_pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_readdmem;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_branch_taken;
  logic              dmem_wait;
  logic              pc_write;
  logic              ifid_write;
  logic              pc_sel;
  logic              flush;
  logic              ifid_flush;
  logic [1:0]        busy_state;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  squash_cnt;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
    output ex_readdmem, ex_rd_addr, ex_branch_taken, dmem_wait,
    input  pc_write, ifid_write, pc_sel, flush, ifid_flush,
    input  busy_state, bubble_cnt, squash_cnt
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
    input  ex_readdmem, ex_rd_addr, ex_branch_taken, dmem_wait,
    output pc_write, ifid_write, pc_sel, flush, ifid_flush,
    output busy_state, bubble_cnt, squash_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_r;

  // count events, holding at the maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// ID-stage hazard controller: load-use bubbles, taken-branch squash and data-memory
// freeze, with Mealy control outputs and saturating bubble/squash counters.
module hazard_flush_ctrl #(
  parameter int REG_AW       = kgp_pipe_pkg::REG_AW,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_flush_ctrl_if.slave   bus
);
  import kgp_pipe_pkg::*;

  localparam logic [REG_AW-1:0]      ZERO_REG   = '0;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 state_r;
  state_e                 ret_state_r;
  logic [FLUSH_CNT_W-1:0] cnt_r;

  state_e                 eff_state_s;
  state_e                 nxt_state_s;
  state_e                 nxt_ret_s;
  state_e                 busy_s;
  logic [FLUSH_CNT_W-1:0] nxt_cnt_s;
  ctrl_t                  ctrl_s;
  logic                   lu_hz_s;
  logic                   inc_bubble_s;
  logic                   inc_squash_s;

  // load-use detection; $zero is hardwired and never a real dependency
  assign lu_hz_s = bus.ex_readdmem && (bus.ex_rd_addr != ZERO_REG) &&
                   ((bus.id_uses_rs && (bus.id_rs_addr == bus.ex_rd_addr)) ||
                    (bus.id_uses_rt && (bus.id_rt_addr == bus.ex_rd_addr)));

  // while frozen the stored return state governs, so release reacts with no dead cycle
  assign eff_state_s = (state_r == MEM_WAIT) ? ret_state_r : state_r;

  // next-state, control word and counter-increment decode
  always_comb begin
    ctrl_s       = CTRL_RUN;
    nxt_state_s  = eff_state_s;
    nxt_ret_s    = ret_state_r;
    nxt_cnt_s    = cnt_r;
    inc_bubble_s = 1'b0;
    inc_squash_s = 1'b0;
    if (rst) begin
      ctrl_s      = CTRL_RESET;
      nxt_state_s = RUN;
      nxt_ret_s   = RUN;
      nxt_cnt_s   = '0;
    end else if (bus.dmem_wait) begin
      // a frozen ID/EX must not be bubbled, so the freeze word carries no flush
      ctrl_s = CTRL_NOP;
      if (eff_state_s == RUN) begin
        nxt_state_s = MEM_WAIT;
        nxt_ret_s   = RUN;
      end else begin
        nxt_state_s = state_r;
      end
    end else begin
      case (eff_state_s)
        RUN, LOAD_STALL: begin
          if (bus.ex_branch_taken) begin
            ctrl_s       = CTRL_BRANCH;
            nxt_cnt_s    = FLUSH_LOAD;
            nxt_state_s  = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
            inc_squash_s = 1'b1;
          end else if ((eff_state_s == RUN) && lu_hz_s) begin
            ctrl_s       = CTRL_BUBBLE;
            nxt_state_s  = LOAD_STALL;
            inc_bubble_s = 1'b1;
          end else begin
            ctrl_s      = CTRL_RUN;
            nxt_state_s = RUN;
          end
        end
        BR_FLUSH: begin
          ctrl_s = CTRL_SQUASH;
          if (cnt_r <= 3'd1) begin
            nxt_cnt_s   = '0;
            nxt_state_s = RUN;
          end else begin
            nxt_cnt_s   = cnt_r - 3'd1;
            nxt_state_s = BR_FLUSH;
          end
        end
        default: begin
          ctrl_s      = CTRL_RUN;
          nxt_state_s = RUN;
        end
      endcase
    end
  end

  // debug view: a freeze taken from RUN is reported as MEM_WAIT immediately
  always_comb begin
    if (!rst && bus.dmem_wait && (eff_state_s == RUN)) begin
      busy_s = MEM_WAIT;
    end else begin
      busy_s = eff_state_s;
    end
  end

  // FSM state, return state and squash-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      cnt_r       <= '0;
    end else begin
      state_r     <= nxt_state_s;
      ret_state_r <= nxt_ret_s;
      cnt_r       <= nxt_cnt_s;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_bubble_s),
    .count (bus.bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_squash_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_squash_s),
    .count (bus.squash_cnt)
  );

  assign bus.pc_write   = ctrl_s.pc_write;
  assign bus.ifid_write = ctrl_s.ifid_write;
  assign bus.pc_sel     = ctrl_s.pc_sel;
  assign bus.flush      = ctrl_s.flush;
  assign bus.ifid_flush = ctrl_s.ifid_flush;
  assign bus.busy_state = busy_s;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl (FLUSH_CYCLES=2, CNT_W=4); inputs change on the
// falling edge and outputs are sampled 1 ns later. ctl = {pc_write,ifid_write,pc_sel,flush,ifid_flush}.
module tb_hazard_flush_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [4:0] ctl;

  hazard_flush_ctrl_if #(.REG_AW(5), .CNT_W(4)) bus ();

  hazard_flush_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign ctl = {bus.pc_write, bus.ifid_write, bus.pc_sel, bus.flush, bus.ifid_flush};

  task automatic clear_inputs();
    bus.id_rs_addr      = 5'd0;
    bus.id_rt_addr      = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_readdmem     = 1'b0;
    bus.ex_rd_addr      = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.dmem_wait       = 1'b0;
  endtask

  task automatic set_lu_rs(input logic [4:0] rd);
    bus.ex_readdmem = 1'b1;
    bus.ex_rd_addr  = rd;
    bus.id_rs_addr  = 5'd5;
    bus.id_uses_rs  = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (ctl !== 5'b00011) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00011); end
    end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL idle_ctl: got %b expected %b", ctl, 5'b11000); end
    n_checks++; if (bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d expected 0", bus.busy_state); end
    n_checks++; if (bus.bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_bubble: got %0d expected 0", bus.bubble_cnt); end
    n_checks++; if (bus.squash_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_squash: got %0d expected 0", bus.squash_cnt); end
  endtask

  task automatic test_load_use();
    @(negedge clk); set_lu_rs(5'd5); #1;
    n_checks++; if (ctl !== 5'b00010) begin n_fail++; $display("FAIL lu_stall_ctl: got %b expected %b", ctl, 5'b00010); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL lu_release_ctl: got %b expected %b", ctl, 5'b11000); end
    n_checks++; if (bus.busy_state !== 2'd1) begin n_fail++; $display("FAIL lu_release_state: got %0d expected 1", bus.busy_state); end
    n_checks++; if (bus.bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_bubble_cnt: got %0d expected 1", bus.bubble_cnt); end
    // destination register 0 never stalls
    @(negedge clk); clear_inputs(); set_lu_rs(5'd0); bus.id_rs_addr = 5'd0; #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL lu_r0_ctl: got %b expected %b", ctl, 5'b11000); end
    n_checks++; if (bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL lu_r0_state: got %0d expected 0", bus.busy_state); end
    // rt path match
    @(negedge clk); clear_inputs();
    bus.ex_readdmem = 1'b1; bus.ex_rd_addr = 5'd7; bus.id_rt_addr = 5'd7; bus.id_uses_rt = 1'b1; #1;
    n_checks++; if (ctl !== 5'b00010) begin n_fail++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, 5'b00010); end
    // rt matches but is not read
    @(negedge clk); bus.id_uses_rt = 1'b0; #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL lu_rt_unused_ctl: got %b expected %b", ctl, 5'b11000); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== 5'b11000 || bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL lu_rt_unused_run: got ctl %b state %0d expected 11000 state 0", ctl, bus.busy_state); end
    n_checks++; if (bus.bubble_cnt !== 4'd2) begin n_fail++; $display("FAIL lu_bubble_cnt2: got %0d expected 2", bus.bubble_cnt); end
    clear_inputs();
  endtask

  task automatic test_branch();
    @(negedge clk); clear_inputs(); bus.ex_branch_taken = 1'b1; #1;
    n_checks++; if (ctl !== 5'b11111) begin n_fail++; $display("FAIL br_c0_ctl: got %b expected %b", ctl, 5'b11111); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== 5'b11011) begin n_fail++; $display("FAIL br_c1_ctl: got %b expected %b", ctl, 5'b11011); end
    n_checks++; if (bus.busy_state !== 2'd2) begin n_fail++; $display("FAIL br_c1_state: got %0d expected 2", bus.busy_state); end
    n_checks++; if (bus.squash_cnt !== 4'd1) begin n_fail++; $display("FAIL br_squash_cnt: got %0d expected 1", bus.squash_cnt); end
    @(negedge clk); bus.ex_branch_taken = 1'b0; #1;
    n_checks++; if (ctl !== 5'b11000 || bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL br_c2: got ctl %b state %0d expected 11000 state 0", ctl, bus.busy_state); end
    n_checks++; if (bus.squash_cnt !== 4'd1) begin n_fail++; $display("FAIL br_spurious_ignored: got %0d expected 1", bus.squash_cnt); end
  endtask

  task automatic test_branch_and_lu();
    @(negedge clk); set_lu_rs(5'd5); bus.ex_branch_taken = 1'b1; #1;
    n_checks++; if (ctl !== 5'b11111) begin n_fail++; $display("FAIL brlu_ctl: got %b expected %b", ctl, 5'b11111); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== 5'b11011 || bus.busy_state !== 2'd2) begin n_fail++; $display("FAIL brlu_flush: got ctl %b state %0d expected 11011 state 2", ctl, bus.busy_state); end
    n_checks++; if (bus.bubble_cnt !== 4'd2 || bus.squash_cnt !== 4'd2) begin n_fail++; $display("FAIL brlu_counts: got bubble %0d squash %0d expected 2 2", bus.bubble_cnt, bus.squash_cnt); end
    @(negedge clk); clear_inputs(); #1;
    n_checks++; if (ctl !== 5'b11000) begin n_fail++; $display("FAIL brlu_resume: got %b expected %b", ctl, 5'b11000); end
  endtask

  task automatic test_dmem_wait();
    @(negedge clk); bus.ex_branch_taken = 1'b1; #1;
    n_checks++; if (ctl !== 5'b11111) begin n_fail++; $display("FAIL mw_br_ctl: got %b expected %b", ctl, 5'b11111); end
    @(negedge clk); bus.ex_branch_taken = 1'b0; bus.dmem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (ctl !== 5'b00000 || bus.busy_state !== 2'd2) begin n_fail++; $display("FAIL mw_freeze_%0d: got ctl %b state %0d expected 00000 state 2", i, ctl, bus.busy_state); end
    end
    @(negedge clk); bus.dmem_wait = 1'b0; #1;
    n_checks++; if (ctl !== 5'b11011 || bus.busy_state !== 2'd2) begin n_fail++; $display("FAIL mw_resume_flush: got ctl %b state %0d expected 11011 state 2", ctl, bus.busy_state); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== 5'b11000 || bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL mw_run: got ctl %b state %0d expected 11000 state 0", ctl, bus.busy_state); end
    n_checks++; if (bus.squash_cnt !== 4'd3) begin n_fail++; $display("FAIL mw_squash_cnt: got %0d expected 3", bus.squash_cnt); end
    // freeze from RUN, released straight into a load-use hazard
    @(negedge clk); bus.dmem_wait = 1'b1; set_lu_rs(5'd5); #1;
    n_checks++; if (ctl !== 5'b00000 || bus.busy_state !== 2'd3) begin n_fail++; $display("FAIL mw_run_freeze0: got ctl %b state %0d expected 00000 state 3", ctl, bus.busy_state); end
    @(negedge clk); #1;
    n_checks++; if (ctl !== 5'b00000 || bus.busy_state !== 2'd3) begin n_fail++; $display("FAIL mw_run_freeze1: got ctl %b state %0d expected 00000 state 3", ctl, bus.busy_state); end
    @(negedge clk); bus.dmem_wait = 1'b0; #1;
    n_checks++; if (ctl !== 5'b00010 || bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL mw_release_lu: got ctl %b state %0d expected 00010 state 0", ctl, bus.busy_state); end
    @(negedge clk); clear_inputs(); #1;
    n_checks++; if (ctl !== 5'b11000 || bus.busy_state !== 2'd1) begin n_fail++; $display("FAIL mw_stall_done: got ctl %b state %0d expected 11000 state 1", ctl, bus.busy_state); end
    n_checks++; if (bus.bubble_cnt !== 4'd3) begin n_fail++; $display("FAIL mw_bubble_cnt: got %0d expected 3", bus.bubble_cnt); end
  endtask

  task automatic test_saturation();
    @(negedge clk); set_lu_rs(5'd5);
    // lu held: alternating RUN(stall)/LOAD_STALL gives one bubble per two cycles
    for (int i = 0; i < 40; i++) @(negedge clk);
    #1;
    n_checks++; if (ctl !== 5'b00010) begin n_fail++; $display("FAIL sat_stall_ctl: got %b expected %b", ctl, 5'b00010); end
    n_checks++; if (bus.bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_bubble_cnt: got %0d expected 15", bus.bubble_cnt); end
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (ctl !== 5'b00011 || bus.busy_state !== 2'd1) begin n_fail++; $display("FAIL sat_rst_in_stall: got ctl %b state %0d expected 00011 state 1", ctl, bus.busy_state); end
    @(negedge clk); rst = 1'b0; clear_inputs(); #1;
    n_checks++; if (ctl !== 5'b11000 || bus.busy_state !== 2'd0) begin n_fail++; $display("FAIL sat_after_rst: got ctl %b state %0d expected 11000 state 0", ctl, bus.busy_state); end
    n_checks++; if (bus.bubble_cnt !== 4'd0 || bus.squash_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_counters_cleared: got bubble %0d squash %0d expected 0 0", bus.bubble_cnt, bus.squash_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_and_lu();
    test_dmem_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Generates the `flush`, stall and redirect controls that the ID-stage flush mux consumes to zero ID/EX control bits.
- Handles three hazard sources:
  - load-use hazard: inserts a one-cycle bubble;
  - taken branch/jump resolved in EX: squashes younger instructions for a configurable number of cycles;
  - data-memory wait: freezes the whole pipeline.
- Sits beside the ID stage. Its inputs come from IF/ID, ID/EX and the data memory.
- Keeps saturating performance counters of bubbles and squashes.

Parameters:
- REG_AW, 5, register address width
- FLUSH_CYCLES, 2, squash cycles per taken branch (legal range 1..7)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs_addr  in  REG_AW  source reg 1 of the instruction in ID
- id_rt_addr  in  REG_AW  source reg 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_readdmem  in  1  instruction in EX is a load
- ex_rd_addr  in  REG_AW  destination of the EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- dmem_wait  in  1  data memory not ready; pipeline must hold
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- pc_sel  out  1  1 = PC loads the branch target
- flush  out  1  drives the ID-stage flush mux (bubble into ID/EX)
- ifid_flush  out  1  clear IF/ID to NOP
- busy_state  out  2  current FSM state, for debug
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
- squash_cnt  out  CNT_W  taken branches squashed, saturating

Behaviour:
- FSM states:
  - RUN=0
  - LOAD_STALL=1
  - BR_FLUSH=2
  - MEM_WAIT=3
- Hazard term `lu_hz`:
  - `lu_hz` = ex_readdmem & ex_rd_addr!=0 & ((id_uses_rs & id_rs_addr==ex_rd_addr) | (id_uses_rt & id_rt_addr==ex_rd_addr)).
  - Register 0 never causes a hazard.
- Outputs are combinational from state, counter and current inputs (Mealy). This gives zero-cycle reaction.
- Priority within a cycle, highest first:
  1. rst
  2. dmem_wait
  3. ex_branch_taken (only in RUN/LOAD_STALL)
  4. `lu_hz`
- rst high:
  - pc_write=0, ifid_write=0, pc_sel=0, flush=1, ifid_flush=1.
  - Next state RUN, flush counter 0, both perf counters 0.
- dmem_wait high (any state):
  - pc_write=0, ifid_write=0, flush=0, ifid_flush=0, pc_sel=0.
  - State and flush counter hold; a frozen ID/EX must not be bubbled.
  - If the state is RUN, busy_state shows MEM_WAIT; the return state is stored and restored when dmem_wait falls.
- RUN, ex_branch_taken=1:
  - pc_sel=1, pc_write=1, flush=1, ifid_flush=1.
  - Counter loads FLUSH_CYCLES-1.
  - Next state is BR_FLUSH if FLUSH_CYCLES>1, else RUN.
  - squash_cnt increments.
- RUN, `lu_hz`=1 (no branch):
  - pc_write=0, ifid_write=0, flush=1, ifid_flush=0.
  - Next state LOAD_STALL; bubble_cnt increments.
- RUN otherwise: all enables 1, flush=0, ifid_flush=0.
- LOAD_STALL:
  - Lasts exactly one cycle. All enables are 1 and flush=0; `lu_hz` is ignored because the load has moved to MEM.
  - Next state RUN.
  - A branch taken in this cycle is handled exactly as in RUN.
- BR_FLUSH:
  - flush=1, ifid_flush=1, pc_write=1, pc_sel=0.
  - ex_branch_taken and `lu_hz` are ignored, since they come from squashed instructions.
  - Counter decrements; when the counter is 0 at the clock edge, next state is RUN.
- Counters: saturate at all-ones; no wrap.
- rst asserted mid-stall or mid-flush: abandons the operation immediately and takes effect on the next edge.

Decomposition:
- Shared package `kgp_pipe_pkg` holds:
  - state encoding constants (RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT);
  - REG_AW;
  - a NOP control-word constant.
- One sub-module, `sat_counter` (parameter CNT_W; inputs clk, rst, inc; output count), instantiated twice.
- The load-use comparator stays inline.

Test Plan:
1. Reset, then idle. Hold rst 3 cycles → flush=1, pc_write=0 during rst. After release, pc_write=1, flush=0, busy_state=0, bubble_cnt=0.
2. Load-use. ex_readdmem=1, ex_rd_addr=5, id_rs_addr=5, id_uses_rs=1 → one cycle of pc_write=0, ifid_write=0, flush=1. Next cycle all enables 1. bubble_cnt=1. Repeat with ex_rd_addr=0 → no stall.
3. Taken branch, FLUSH_CYCLES=2. Pulse ex_branch_taken → cycle 0: pc_sel=1, flush=1, ifid_flush=1. Cycle 1: flush=1, pc_sel=0, and a spurious ex_branch_taken is ignored. Cycle 2: flush=0. squash_cnt=1.
4. Simultaneous branch and load-use in RUN → branch path only; bubble_cnt unchanged, squash_cnt +1.
5. dmem_wait for 4 cycles in the middle of BR_FLUSH → all enables 0 and flush=0 throughout. Remaining flush cycles resume after dmem_wait falls, with busy_state back to 2.
6. Saturation with CNT_W=4. Run 20 load-use stalls → bubble_cnt stays at 15. Then rst asserted during LOAD_STALL → RUN next cycle and counters 0.
